serial_adder: RTL and testbench

Multi-cycle, parametrised successor to the ALU half adder. Adds two WIDTH-bit operands CHUNK bits per clock through one small ripple stage, carrying between chunks in a flip-flop, and produces sum, carry-out and signed overflow. It sits in the ALU as the area-cheap adder path, driven by a start/done handshake from the ALU sequencer.

---
 rtl/alu_pkg.sv | 13 +
 rtl/half_adder.sv | 12 +
 rtl/ripple_chunk.sv | 32 +++
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial adder FSM states and default operand geometry.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CHUNK = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } serial_adder_state_t;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder; the building block of the ripple stages.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/ripple_chunk.sv
// CHUNK-bit ripple-carry stage made of full adders built from two half adders.
// Also exposes the carry into the chunk MSB so the caller can derive overflow.
module ripple_chunk #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a_chunk,
    input  logic [CHUNK-1:0] b_chunk,
    input  logic             carry,
    output logic [CHUNK-1:0] sum_chunk,
    output logic             carry_next,
    output logic             carry_top
);

    logic [CHUNK:0] c;

    assign c[0] = carry;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic s1;
        logic c1;
        logic c2;

        half_adder u_ha0 (.x(a_chunk[i]), .y(b_chunk[i]), .s(s1),           .c(c1));
        half_adder u_ha1 (.x(s1),         .y(c[i]),       .s(sum_chunk[i]), .c(c2));

        assign c[i+1] = c1 | c2;
    end

    assign carry_next = c[CHUNK];
    assign carry_top  = c[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: CHUNK bits per clock through one ripple stage, start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub port and subtract mode.
module serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int K     = WIDTH / CHUNK;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("serial_adder: CHUNK must divide WIDTH");
    end

    serial_adder_state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_sr_next;
    logic             carry_q;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [CHUNK-1:0] sum_chunk;
    logic             carry_next;
    logic             carry_top;
    logic             last;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + ~cin, so cout=1 means no borrow.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = cin ^ sub;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_chunk   (a_sh[CHUNK-1:0]),
        .b_chunk   (b_sh[CHUNK-1:0]),
        .carry     (carry_q),
        .sum_chunk (sum_chunk),
        .carry_next(carry_next),
        .carry_top (carry_top)
    );

    assign last        = (cnt == CNT_W'(K - 1));
    assign sum_sr_next = (sum_sr >> CHUNK) | (WIDTH'(sum_chunk) << (WIDTH - CHUNK));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the whole datapath shares the reset, so an aborted run leaves no stale carry or partial sum.
        if (rst) begin
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh    <= a;
                    b_sh    <= b_eff;
                    carry_q <= cin_eff;
                    cnt     <= '0;
                    sum_sr  <= '0;
                end
                RUN: begin
                    a_sh    <= a_sh >> CHUNK;
                    b_sh    <= b_sh >> CHUNK;
                    carry_q <= carry_next;
                    sum_sr  <= sum_sr_next;
                    cnt     <= cnt + 1'b1;
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    if (last) begin
                        sum  <= sum_sr_next;
                        cout <= carry_next;
                        ovf  <= carry_top ^ carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three instances (8/1, 8/2, 16/16) sharing clock and reset.
// Latency is measured as edges from the accepting edge to the first cycle with done high.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    logic start1, start2, start3;
    logic [7:0]  a8, b8;
    logic        cin8;
    logic [15:0] a16, b16;
    logic        cin16;
`ifdef SERIAL_ADDER_SUB_EN
    logic sub8, sub16;
`endif

    logic busy1, done1, cout1, ovf1;
    logic busy2, done2, cout2, ovf2;
    logic busy3, done3, cout3, ovf3;
    logic [7:0]  sum1, sum2;
    logic [15:0] sum3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(8), .CHUNK(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    serial_adder #(.WIDTH(16), .CHUNK(16)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub16),
`endif
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
    );

    // Issue one operation on the 8-bit instance sel (0: CHUNK=1, 1: CHUNK=2) and collect its result.
    task automatic run8(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic sv,
                        output int lat, output int busy_cnt, output logic [7:0] s,
                        output logic co, output logic ov, output logic done_after);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = sv;
`else
        if (sv) $display("note: sub requested without subtract support");
`endif
        if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        lat = 0; busy_cnt = 0;
        while (lat < 40 && !((sel == 0) ? done1 : done2)) begin
            if ((sel == 0) ? busy1 : busy2) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        s  = (sel == 0) ? sum1  : sum2;
        co = (sel == 0) ? cout1 : cout2;
        ov = (sel == 0) ? ovf1  : ovf2;
        @(negedge clk);
        done_after = (sel == 0) ? done1 : done2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy1, done1, sum1, cout1, ovf1} !== 11'd0) begin
            bad++; $display("FAIL reset_dut1 got=%h want=0", {busy1, done1, sum1, cout1, ovf1});
        end
        total++;
        if ({busy2, done2, sum2, cout2, ovf2} !== 11'd0) begin
            bad++; $display("FAIL reset_dut2 got=%h want=0", {busy2, done2, sum2, cout2, ovf2});
        end
        total++;
        if ({busy3, done3, sum3, cout3, ovf3} !== 19'd0) begin
            bad++; $display("FAIL reset_dut3 got=%h want=0", {busy3, done3, sum3, cout3, ovf3});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy1, done1} !== 2'b00) begin
            bad++; $display("FAIL idle_after_reset got busy/done=%b want=00", {busy1, done1});
        end
    endtask

    task automatic test_wrap;
        int lat, bc; logic [7:0] s; logic co, ov, da;
        run8(0, 8'hFF, 8'h01, 1'b0, 1'b0, lat, bc, s, co, ov, da);
        total++;
        if (lat !== 8) begin bad++; $display("FAIL wrap_latency got=%0d want=8", lat); end
        total++;
        if (bc !== 8) begin bad++; $display("FAIL wrap_busy_cycles got=%0d want=8", bc); end
        total++;
        if ({s, co, ov} !== {8'h00, 1'b1, 1'b0}) begin
            bad++; $display("FAIL wrap_result got sum=%h cout=%b ovf=%b want sum=00 cout=1 ovf=0", s, co, ov);
        end
        total++;
        if (da !== 1'b0) begin bad++; $display("FAIL wrap_done_pulse got done=%b want=0 one cycle later", da); end
    endtask

    task automatic test_vectors;
        logic [7:0] va [3] = '{8'h80, 8'h40, 8'h3C};
        logic [7:0] vb [3] = '{8'h80, 8'h40, 8'hA5};
        logic       vc [3] = '{1'b1,  1'b0,  1'b1};
        logic [7:0] es [3] = '{8'h01, 8'h80, 8'hE2};
        logic       ec [3] = '{1'b1,  1'b0,  1'b0};
        logic       eo [3] = '{1'b1,  1'b1,  1'b0};
        for (int i = 0; i < 3; i++) begin
            int lat, bc; logic [7:0] s; logic co, ov, da;
            run8(0, va[i], vb[i], vc[i], 1'b0, lat, bc, s, co, ov, da);
            total++;
            if ({s, co, ov} !== {es[i], ec[i], eo[i]}) begin
                bad++;
                $display("FAIL vector%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, s, co, ov, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        logic seen_done = 1'b0;
        int lat, bc; logic [7:0] s; logic co, ov, da;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy1, done1, sum1, cout1, ovf1} !== 11'd0) begin
            bad++; $display("FAIL midrun_reset got=%h want=0", {busy1, done1, sum1, cout1, ovf1});
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done1) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) begin bad++; $display("FAIL midrun_no_done got done seen=1 want=0"); end
        run8(0, 8'h55, 8'h0F, 1'b0, 1'b0, lat, bc, s, co, ov, da);
        total++;
        if ({s, co, ov} !== {8'h64, 1'b0, 1'b0} || lat !== 8) begin
            bad++; $display("FAIL midrun_restart got sum=%h cout=%b ovf=%b lat=%0d want sum=64 cout=0 ovf=0 lat=8",
                            s, co, ov, lat);
        end
    endtask

    task automatic test_chunk2;
        int lat, bc; logic [7:0] s; logic co, ov, da;
        run8(1, 8'h7F, 8'h01, 1'b0, 1'b0, lat, bc, s, co, ov, da);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL chunk2_latency got=%0d want=4", lat); end
        total++;
        if ({s, co, ov} !== {8'h80, 1'b0, 1'b1}) begin
            bad++; $display("FAIL chunk2_result got sum=%h cout=%b ovf=%b want sum=80 cout=0 ovf=1", s, co, ov);
        end
    endtask

    task automatic test_back_to_back;
        int dones = 0, first = -1, prev = -1;
        logic space_ok = 1'b1, sum_ok = 1'b1;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start1 = 1'b1;
        for (int i = 1; i < 35; i++) begin
            @(negedge clk);
            if (done1) begin
                dones++;
                if ({sum1, cout1, ovf1} !== {8'h30, 1'b0, 1'b0}) sum_ok = 1'b0;
                if (prev >= 0 && i - prev != 10) space_ok = 1'b0;
                if (first < 0) first = i;
                prev = i;
            end
            // Scramble operands while running; restore them whenever a start could be accepted.
            if (busy1) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end else begin
                a8 = 8'h10; b8 = 8'h20;
            end
        end
        start1 = 1'b0;
        a8 = 8'h10; b8 = 8'h20;
        repeat (12) @(negedge clk);
        total++;
        if (dones !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", dones); end
        total++;
        if (first !== 9) begin bad++; $display("FAIL b2b_first got=%0d want=9", first); end
        total++;
        if (space_ok !== 1'b1) begin bad++; $display("FAIL b2b_spacing got irregular want=10 cycles"); end
        total++;
        if (sum_ok !== 1'b1) begin bad++; $display("FAIL b2b_sum got sum=%h want=30", sum1); end
    endtask

    task automatic test_wide;
        int lat = 0;
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        while (lat < 40 && !done3) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 1) begin bad++; $display("FAIL wide_latency got=%0d want=1", lat); end
        total++;
        if ({sum3, cout3, ovf3} !== {16'hFFFF, 1'b1, 1'b0}) begin
            bad++; $display("FAIL wide_result got sum=%h cout=%b ovf=%b want sum=ffff cout=1 ovf=0", sum3, cout3, ovf3);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int lat, bc; logic [7:0] s; logic co, ov, da;
        run8(0, 8'h05, 8'h07, 1'b0, 1'b1, lat, bc, s, co, ov, da);
        total++;
        if ({s, co, ov} !== {8'hFE, 1'b0, 1'b0}) begin
            bad++; $display("FAIL sub_borrow got sum=%h cout=%b ovf=%b want sum=fe cout=0 ovf=0", s, co, ov);
        end
        run8(0, 8'h80, 8'h01, 1'b0, 1'b1, lat, bc, s, co, ov, da);
        total++;
        if ({s, co, ov} !== {8'h7F, 1'b1, 1'b1}) begin
            bad++; $display("FAIL sub_ovf got sum=%h cout=%b ovf=%b want sum=7f cout=1 ovf=1", s, co, ov);
        end
        sub8 = 1'b0;
    endtask
`endif

    initial begin
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0; sub16 = 1'b0;
`endif
        test_reset();
        test_wrap();
        test_vectors();
        test_reset_mid_run();
        test_chunk2();
        test_back_to_back();
        test_wide();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
